zeroheti_apb_mgr: RTL

ZEROHETI_APB_MGR -- requirements
Module: zeroheti_apb_mgr

---
 rtl/zeroheti_pkg.sv | 5 +
 rtl/zeroheti_apb_mgr_if.sv | 23 ++
 rtl/zeroheti_apb_mgr.sv | 86 ++++++++
 3 files changed

// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg: shared types and constants for the zeroheti APB manager
package zeroheti_pkg;
   localparam int unsigned TimeoutCntWidth = 16;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_mgr_state_e;
endpackage

// File: rtl/zeroheti_apb_mgr_if.sv
// zeroheti_apb_mgr_if: APB bus bundle with manager and completer views
interface zeroheti_apb_mgr_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic [AddrWidth-1:0]   paddr;
   logic                   psel;
   logic                   penable;
   logic                   pwrite;
   logic [DataWidth-1:0]   pwdata;
   logic [DataWidth/8-1:0] pstrb;
   logic [DataWidth-1:0]   prdata;
   logic                   pready;
   logic                   pslverr;
   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  prdata, pready, pslverr
   );
   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/zeroheti_apb_mgr.sv
// zeroheti_apb_mgr: core request/response channel to APB manager bridge
// with a wait-state timeout that aborts stalled ACCESS phases.
module zeroheti_apb_mgr
   import zeroheti_pkg::*;
#(
   parameter int AddrWidth     = 32,
   parameter int DataWidth     = 32,
   parameter int TimeoutCycles = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_i,
   output logic                   gnt_o,
   input  logic [AddrWidth-1:0]   addr_i,
   input  logic                   we_i,
   input  logic [DataWidth/8-1:0] be_i,
   input  logic [DataWidth-1:0]   wdata_i,
   output logic                   rvalid_o,
   output logic [DataWidth-1:0]   rdata_o,
   output logic                   err_o,
   output logic [AddrWidth-1:0]   paddr_o,
   output logic                   psel_o,
   output logic                   penable_o,
   output logic                   pwrite_o,
   output logic [DataWidth-1:0]   pwdata_o,
   output logic [DataWidth/8-1:0] pstrb_o,
   input  logic [DataWidth-1:0]   prdata_i,
   input  logic                   pready_i,
   input  logic                   pslverr_i,
   output logic                   timeout_o
);
   apb_mgr_state_e               r_state;
   logic [TimeoutCntWidth-1:0]   r_cnt;
   logic                         w_limit;

   assign gnt_o   = req_i && (r_state == IDLE);
   assign w_limit = r_cnt == TimeoutCntWidth'(TimeoutCycles);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         paddr_o   <= '0;
         psel_o    <= 1'b0;
         penable_o <= 1'b0;
         pwrite_o  <= 1'b0;
         pwdata_o  <= '0;
         pstrb_o   <= '0;
         rvalid_o  <= 1'b0;
         rdata_o   <= '0;
         err_o     <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         rvalid_o  <= 1'b0;
         timeout_o <= 1'b0;
         case (r_state)
            IDLE: if (req_i) begin
               r_state  <= SETUP;
               psel_o   <= 1'b1;
               paddr_o  <= addr_i;
               pwrite_o <= we_i;
               pwdata_o <= we_i ? wdata_i : '0;
               pstrb_o  <= we_i ? be_i : '0;
            end
            SETUP: begin
               r_state   <= ACCESS;
               penable_o <= 1'b1;
               r_cnt     <= '0;
            end
            ACCESS: if (pready_i || w_limit) begin
               // a ready completer wins over an expiring count in the same cycle
               r_state   <= IDLE;
               psel_o    <= 1'b0;
               penable_o <= 1'b0;
               rvalid_o  <= 1'b1;
               err_o     <= pready_i ? pslverr_i : 1'b1;
               rdata_o   <= (pready_i && !pwrite_o) ? prdata_i : '0;
               timeout_o <= !pready_i;
            end else begin
               r_cnt <= r_cnt + TimeoutCntWidth'(1);
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
